dram_access_ctrl: RTL and testbench
===================================

# dram_access_ctrl

Single-port access controller for the core's data RAM. It arbitrates between instruction fetch, which reads only, and the load/store unit, which reads and writes (LB/LH/LW/LBU/LHU/SB/SH/SW). It sequences each access as request, RAM cycle and response, and handles byte-lane enables, store-data replication, load extraction and sign extension, and misalignment errors. It sits between the IF/MEM stages and the RAM array.

## Interface
Parameters:
- DEPTH_LOG2, 7: log2 of the RAM word count (128 × 32-bit words).

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req_valid_i  in  1  fetch request.
- if_req_ready_o  out  1  fetch request accepted this cycle.
- if_addr_i  in  32  byte address; bits [1:0] ignored.
- if_rsp_valid_o  out  1  one-cycle pulse; if_rsp_data_o valid.
- if_rsp_data_o  out  32  fetched word.
- lsu_req_valid_i  in  1  load/store request.
- lsu_req_ready_o  out  1  LSU request accepted this cycle.
- lsu_addr_i  in  32  byte address.
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_size_i  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- lsu_unsigned_i  in  1  zero-extend loads (LBU/LHU).
- lsu_wdata_i  in  32  store data, right-aligned.
- lsu_rsp_valid_o  out  1  one-cycle pulse: load data, store ack, or error.
- lsu_rsp_data_o  out  32  extended load data; 0 for stores and errors.
- lsu_err_o  out  1  misaligned access; qualified by lsu_rsp_valid_o.
- ram_en_o  out  1  RAM access strobe.
- ram_we_o  out  1  RAM write.
- ram_be_o  out  4  byte write enables.
- ram_addr_o  out  DEPTH_LOG2  word index.
- ram_wdata_o  out  32  lane-replicated store data.
- ram_rdata_i  in  32  synchronous read data, valid the cycle after ram_en_o.

## Operation
- FSM states:
  - IDLE: ready may assert. On handshake, latch the command and go to ACCESS. A misaligned LSU request goes to ERR instead.
  - ACCESS: drive ram_en_o from the latched command. Stores go to IDLE; loads and fetches go to CAPTURE.
  - CAPTURE: register ram_rdata_i, after extraction and extension for the LSU, into the response data. Go to IDLE.
  - ERR: no RAM access. Go to IDLE.
- Ready: if_req_ready_o and lsu_req_ready_o are combinational. Each is 1 only in IDLE, only for the granted requester, and only when that requester's valid is high. The two are never both 1.
- Arbitration with both valid in IDLE: LSU wins (fixed priority) unless DRAM_ARB_RR_EN is defined.
- Word index: addr[DEPTH_LOG2+1:2]. Higher address bits are ignored, so addresses wrap modulo the RAM size.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << {addr[1],1'b0}.
  - word: 4'b1111.
  - Loads drive be = 0 and we = 0.
- Store data: byte replicated ×4, half replicated ×2, word unchanged.
- Load data: select the lane by addr[1:0], then sign- or zero-extend per lsu_unsigned_i.
- Misaligned: a half with addr[0] = 1, or a word with addr[1:0] != 0. Response is lsu_err_o = 1 with data 0, and the RAM is untouched.
- Outside ACCESS, all ram_* outputs are 0.

## Timing
- Handshake sampled in cycle 0.
- Fetch and load: ram_en_o in cycle 1, data captured at the end of cycle 2, rsp_valid high in cycle 3. IDLE is re-entered in cycle 3, so a new handshake is possible in cycle 3. Peak rate is one read per 3 cycles.
- Store: ram_en_o/ram_we_o in cycle 1, lsu_rsp_valid_o (ack) in cycle 2. Handshake is possible again in cycle 2.
- Error: lsu_rsp_valid_o with lsu_err_o in cycle 2.
- rsp_valid outputs are single-cycle registered pulses with no backpressure. rsp_data and err hold their value until the next response.
- Reset values:
  - State IDLE.
  - All registered outputs 0: rsp_valid, rsp_data, lsu_err_o, ram_en_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o.
  - Round-robin pointer points at IF, so the LSU wins the first tie.
- Reset asserted mid-access aborts the access. No response is issued, and a store in ACCESS may or may not have been written.

## Configuration
- DRAM_ARB_RR_EN defined: round-robin arbitration. A 1-bit last-grant register updates on every handshake, and the requester not granted last wins a tie.
- Not defined: fixed priority, LSU over IF, and no pointer register.

## Structure
- define.v gains:
  - Size encodings LSU_SIZE_B/H/W.
  - FSM state encodings DRAM_ST_IDLE/ACCESS/CAPTURE/ERR.
  - Reuses PORT_ADDR_WIDTH, PORT_DATA_WIDTH, RstEnable and ZeroWord.
- One combinational sub-module, lsu_byte_lane. It covers byte-enable generation, store replication, load extraction and extension, and misalignment detection.

## Test plan
- Fetch at 0x0000_0008 with RAM word 2 = 0xDEADBEEF: ram_addr_o = 2 in cycle 1; if_rsp_data_o = 0xDEADBEEF with valid in cycle 3.
- SB 0xA5 to 0x0000_0013: ram_be_o = 4'b1000, ram_wdata_o = 0xA5A5A5A5, ack in cycle 2. LB then returns 0xFFFFFFA5; LBU returns 0x000000A5.
- LH at 0x0000_0001: lsu_err_o = 1, data 0 in cycle 2, ram_en_o never asserted.
- IF and LSU valid together for 4 transactions each: fixed priority serves all LSU first; under DRAM_ARB_RR_EN grants alternate LSU, IF, LSU, …
- rst_n low during ACCESS of a load: all outputs 0 immediately, no rsp_valid, and the next request is accepted normally.
- Address 0x0000_0204 with DEPTH_LOG2 = 7: ram_addr_o = 1 (wrap).

Source files
------------

// File: rtl/dram_access_ctrl_pkg.sv
// Shared encodings for the data-RAM access controller: LSU access sizes, FSM states
// and common widths.
package dram_access_ctrl_pkg;

    localparam int unsigned PORT_ADDR_WIDTH = 32;
    localparam int unsigned PORT_DATA_WIDTH = 32;

    localparam logic                       RstEnable = 1'b0;
    localparam logic [PORT_DATA_WIDTH-1:0] ZeroWord  = 32'h0000_0000;

    localparam logic [1:0] LSU_SIZE_B = 2'b00;
    localparam logic [1:0] LSU_SIZE_H = 2'b01;
    localparam logic [1:0] LSU_SIZE_W = 2'b10;

    localparam logic [1:0] DRAM_ST_IDLE    = 2'd0;
    localparam logic [1:0] DRAM_ST_ACCESS  = 2'd1;
    localparam logic [1:0] DRAM_ST_CAPTURE = 2'd2;
    localparam logic [1:0] DRAM_ST_ERR     = 2'd3;

endpackage

// File: rtl/dram_access_ctrl_lsu_byte_lane.sv
// LSU byte-lane unit: byte enables, store replication, load extraction/extension and
// misalignment detection. Purely combinational.
module dram_access_ctrl_lsu_byte_lane
    import dram_access_ctrl_pkg::*;
(
    input  logic [1:0]                 i_addr_lo,
    input  logic [1:0]                 i_size,
    input  logic                       i_unsigned,
    input  logic [PORT_DATA_WIDTH-1:0] i_wdata,
    input  logic [PORT_DATA_WIDTH-1:0] i_rdata,
    output logic [3:0]                 o_be,
    output logic [PORT_DATA_WIDTH-1:0] o_wdata,
    output logic [PORT_DATA_WIDTH-1:0] o_rdata,
    output logic                       o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Size 2'b11 falls into the word branch.
    always_comb begin
        o_be         = 4'b1111;
        o_wdata      = i_wdata;
        o_rdata      = i_rdata;
        o_misaligned = |i_addr_lo;
        case (i_size)
            LSU_SIZE_B: begin
                o_be         = 4'b0001 << i_addr_lo;
                o_wdata      = {4{i_wdata[7:0]}};
                o_rdata      = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
                o_misaligned = 1'b0;
            end
            LSU_SIZE_H: begin
                o_be         = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata      = {2{i_wdata[15:0]}};
                o_rdata      = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
                o_misaligned = i_addr_lo[0];
            end
            default: begin
                o_be         = 4'b1111;
                o_wdata      = i_wdata;
                o_rdata      = i_rdata;
                o_misaligned = |i_addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/dram_access_ctrl.sv
// Single-port data-RAM access controller arbitrating instruction fetch and the LSU.
// Define DRAM_ARB_RR_EN for round-robin arbitration; otherwise the LSU has fixed priority.
module dram_access_ctrl
    import dram_access_ctrl_pkg::*;
#(
    parameter int DEPTH_LOG2 = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       if_req_valid_i,
    output logic                       if_req_ready_o,
    input  logic [PORT_ADDR_WIDTH-1:0] if_addr_i,
    output logic                       if_rsp_valid_o,
    output logic [PORT_DATA_WIDTH-1:0] if_rsp_data_o,
    input  logic                       lsu_req_valid_i,
    output logic                       lsu_req_ready_o,
    input  logic [PORT_ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic                       lsu_we_i,
    input  logic [1:0]                 lsu_size_i,
    input  logic                       lsu_unsigned_i,
    input  logic [PORT_DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                       lsu_rsp_valid_o,
    output logic [PORT_DATA_WIDTH-1:0] lsu_rsp_data_o,
    output logic                       lsu_err_o,
    output logic                       ram_en_o,
    output logic                       ram_we_o,
    output logic [3:0]                 ram_be_o,
    output logic [DEPTH_LOG2-1:0]      ram_addr_o,
    output logic [PORT_DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [PORT_DATA_WIDTH-1:0] ram_rdata_i
);

    logic [1:0]                 r_state;
    logic                       r_is_lsu;
    logic                       r_we;
    logic [1:0]                 r_size;
    logic                       r_unsigned;
    logic [1:0]                 r_addr_lo;
    logic                       r_if_rsp_valid;
    logic [PORT_DATA_WIDTH-1:0] r_if_rsp_data;
    logic                       r_lsu_rsp_valid;
    logic [PORT_DATA_WIDTH-1:0] r_lsu_rsp_data;
    logic                       r_lsu_err;
    logic                       r_ram_en;
    logic                       r_ram_we;
    logic [3:0]                 r_ram_be;
    logic [DEPTH_LOG2-1:0]      r_ram_addr;
    logic [PORT_DATA_WIDTH-1:0] r_ram_wdata;

    logic                       w_idle;
    logic                       w_lsu_pri;
    logic                       w_grant_lsu;
    logic                       w_if_hs;
    logic                       w_lsu_hs;
    logic [1:0]                 w_lane_addr_lo;
    logic [1:0]                 w_lane_size;
    logic                       w_lane_unsigned;
    logic [3:0]                 w_be;
    logic [PORT_DATA_WIDTH-1:0] w_wdata;
    logic [PORT_DATA_WIDTH-1:0] w_rdata_ext;
    logic                       w_misaligned;
    logic                       w_unused;

    assign w_idle = (r_state == DRAM_ST_IDLE);

`ifdef DRAM_ARB_RR_EN
    logic r_last_lsu;

    // Reset to "last grant was IF" so the LSU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RstEnable) begin
            r_last_lsu <= 1'b0;
        end else if (w_if_hs || w_lsu_hs) begin
            r_last_lsu <= w_lsu_hs;
        end
    end

    assign w_lsu_pri = ~r_last_lsu;
`else
    assign w_lsu_pri = 1'b1;
`endif

    assign w_grant_lsu     = lsu_req_valid_i & (~if_req_valid_i | w_lsu_pri);
    assign lsu_req_ready_o = w_idle & w_grant_lsu;
    assign if_req_ready_o  = w_idle & if_req_valid_i & ~w_grant_lsu;
    assign w_lsu_hs        = lsu_req_ready_o;
    assign w_if_hs         = if_req_ready_o;

    // Live request fields feed the lane unit in IDLE; latched fields drive load extraction.
    assign w_lane_addr_lo  = w_idle ? lsu_addr_i[1:0] : r_addr_lo;
    assign w_lane_size     = w_idle ? lsu_size_i      : r_size;
    assign w_lane_unsigned = w_idle ? lsu_unsigned_i  : r_unsigned;

    dram_access_ctrl_lsu_byte_lane u_byte_lane (
        .i_addr_lo    (w_lane_addr_lo),
        .i_size       (w_lane_size),
        .i_unsigned   (w_lane_unsigned),
        .i_wdata      (lsu_wdata_i),
        .i_rdata      (ram_rdata_i),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_rdata      (w_rdata_ext),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RstEnable) begin
            r_state         <= DRAM_ST_IDLE;
            r_is_lsu        <= 1'b0;
            r_we            <= 1'b0;
            r_size          <= LSU_SIZE_B;
            r_unsigned      <= 1'b0;
            r_addr_lo       <= 2'b00;
            r_if_rsp_valid  <= 1'b0;
            r_if_rsp_data   <= ZeroWord;
            r_lsu_rsp_valid <= 1'b0;
            r_lsu_rsp_data  <= ZeroWord;
            r_lsu_err       <= 1'b0;
            r_ram_en        <= 1'b0;
            r_ram_we        <= 1'b0;
            r_ram_be        <= 4'b0000;
            r_ram_addr      <= '0;
            r_ram_wdata     <= ZeroWord;
        end else begin
            r_if_rsp_valid  <= 1'b0;
            r_lsu_rsp_valid <= 1'b0;
            case (r_state)
                DRAM_ST_IDLE: begin
                    if (w_lsu_hs) begin
                        r_is_lsu   <= 1'b1;
                        r_we       <= lsu_we_i;
                        r_size     <= lsu_size_i;
                        r_unsigned <= lsu_unsigned_i;
                        r_addr_lo  <= lsu_addr_i[1:0];
                        if (w_misaligned) begin
                            r_state <= DRAM_ST_ERR;
                        end else begin
                            r_state     <= DRAM_ST_ACCESS;
                            r_ram_en    <= 1'b1;
                            r_ram_we    <= lsu_we_i;
                            r_ram_be    <= lsu_we_i ? w_be : 4'b0000;
                            r_ram_addr  <= lsu_addr_i[DEPTH_LOG2+1:2];
                            r_ram_wdata <= lsu_we_i ? w_wdata : ZeroWord;
                        end
                    end else if (w_if_hs) begin
                        r_is_lsu    <= 1'b0;
                        r_we        <= 1'b0;
                        r_state     <= DRAM_ST_ACCESS;
                        r_ram_en    <= 1'b1;
                        r_ram_we    <= 1'b0;
                        r_ram_be    <= 4'b0000;
                        r_ram_addr  <= if_addr_i[DEPTH_LOG2+1:2];
                        r_ram_wdata <= ZeroWord;
                    end
                end
                DRAM_ST_ACCESS: begin
                    r_ram_en    <= 1'b0;
                    r_ram_we    <= 1'b0;
                    r_ram_be    <= 4'b0000;
                    r_ram_addr  <= '0;
                    r_ram_wdata <= ZeroWord;
                    if (r_is_lsu && r_we) begin
                        r_lsu_rsp_valid <= 1'b1;
                        r_lsu_rsp_data  <= ZeroWord;
                        r_lsu_err       <= 1'b0;
                        r_state         <= DRAM_ST_IDLE;
                    end else begin
                        r_state <= DRAM_ST_CAPTURE;
                    end
                end
                DRAM_ST_CAPTURE: begin
                    if (r_is_lsu) begin
                        r_lsu_rsp_valid <= 1'b1;
                        r_lsu_rsp_data  <= w_rdata_ext;
                        r_lsu_err       <= 1'b0;
                    end else begin
                        r_if_rsp_valid <= 1'b1;
                        r_if_rsp_data  <= ram_rdata_i;
                    end
                    r_state <= DRAM_ST_IDLE;
                end
                DRAM_ST_ERR: begin
                    r_lsu_rsp_valid <= 1'b1;
                    r_lsu_rsp_data  <= ZeroWord;
                    r_lsu_err       <= 1'b1;
                    r_state         <= DRAM_ST_IDLE;
                end
                default: r_state <= DRAM_ST_IDLE;
            endcase
        end
    end

    assign if_rsp_valid_o  = r_if_rsp_valid;
    assign if_rsp_data_o   = r_if_rsp_data;
    assign lsu_rsp_valid_o = r_lsu_rsp_valid;
    assign lsu_rsp_data_o  = r_lsu_rsp_data;
    assign lsu_err_o       = r_lsu_err;
    assign ram_en_o        = r_ram_en;
    assign ram_we_o        = r_ram_we;
    assign ram_be_o        = r_ram_be;
    assign ram_addr_o      = r_ram_addr;
    assign ram_wdata_o     = r_ram_wdata;

    // Address bits outside the word index are intentionally ignored (wrap).
    assign w_unused = ^{if_addr_i[PORT_ADDR_WIDTH-1:DEPTH_LOG2+2], if_addr_i[1:0],
                        lsu_addr_i[PORT_ADDR_WIDTH-1:DEPTH_LOG2+2]};

endmodule

// File: tb/tb_dram_access_ctrl.sv
// Scoreboard bench for dram_access_ctrl: drivers push expected responses and RAM commands,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_dram_access_ctrl;

    localparam int DEPTH_LOG2 = 7;
    localparam int WORDS      = 1 << DEPTH_LOG2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  if_req_valid_i = 1'b0;
    logic                  if_req_ready_o;
    logic [31:0]           if_addr_i = '0;
    logic                  if_rsp_valid_o;
    logic [31:0]           if_rsp_data_o;
    logic                  lsu_req_valid_i = 1'b0;
    logic                  lsu_req_ready_o;
    logic [31:0]           lsu_addr_i = '0;
    logic                  lsu_we_i = 1'b0;
    logic [1:0]            lsu_size_i = '0;
    logic                  lsu_unsigned_i = 1'b0;
    logic [31:0]           lsu_wdata_i = '0;
    logic                  lsu_rsp_valid_o;
    logic [31:0]           lsu_rsp_data_o;
    logic                  lsu_err_o;
    logic                  ram_en_o;
    logic                  ram_we_o;
    logic [3:0]            ram_be_o;
    logic [DEPTH_LOG2-1:0] ram_addr_o;
    logic [31:0]           ram_wdata_o;
    logic [31:0]           ram_rdata_i;

    always #5 clk = ~clk;

    dram_access_ctrl #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_req_valid_i  (if_req_valid_i),
        .if_req_ready_o  (if_req_ready_o),
        .if_addr_i       (if_addr_i),
        .if_rsp_valid_o  (if_rsp_valid_o),
        .if_rsp_data_o   (if_rsp_data_o),
        .lsu_req_valid_i (lsu_req_valid_i),
        .lsu_req_ready_o (lsu_req_ready_o),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_size_i      (lsu_size_i),
        .lsu_unsigned_i  (lsu_unsigned_i),
        .lsu_wdata_i     (lsu_wdata_i),
        .lsu_rsp_valid_o (lsu_rsp_valid_o),
        .lsu_rsp_data_o  (lsu_rsp_data_o),
        .lsu_err_o       (lsu_err_o),
        .ram_en_o        (ram_en_o),
        .ram_we_o        (ram_we_o),
        .ram_be_o        (ram_be_o),
        .ram_addr_o      (ram_addr_o),
        .ram_wdata_o     (ram_wdata_o),
        .ram_rdata_i     (ram_rdata_i)
    );

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] v;
        v = 32'(i);
        if (i == 2) return 32'hDEAD_BEEF;
        return (v * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Environment RAM with synchronous read.
    logic [31:0] mem [WORDS];
    logic        init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= init_word(i);
        end else if (ram_en_o) begin
            ram_rdata_i <= mem[ram_addr_o];
            if (ram_we_o)
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] data; logic err; int cyc; } rsp_t;
    typedef struct { logic [DEPTH_LOG2-1:0] addr; logic we; logic [3:0] be;
                     logic [31:0] wdata; int cyc; } ram_t;

    logic [31:0] ref_mem [WORDS];
    rsp_t        if_q[$];
    rsp_t        lsu_q[$];
    ram_t        ram_q[$];
    logic [7:0]  grant_log[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare everything the DUT presents against the scoreboard queues.
    initial begin
        rsp_t e;
        ram_t m;
        forever begin
            @(negedge clk);
            if (if_rsp_valid_o) begin
                check("if_rsp_expected", {31'b0, if_q.size() != 0}, 32'd1);
                if (if_q.size() != 0) begin
                    e = if_q.pop_front();
                    check("if_rsp_data", if_rsp_data_o, e.data);
                    check("if_rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (lsu_rsp_valid_o) begin
                check("lsu_rsp_expected", {31'b0, lsu_q.size() != 0}, 32'd1);
                if (lsu_q.size() != 0) begin
                    e = lsu_q.pop_front();
                    check("lsu_rsp_data", lsu_rsp_data_o, e.data);
                    check("lsu_err", {31'b0, lsu_err_o}, {31'b0, e.err});
                    check("lsu_rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (ram_en_o) begin
                check("ram_access_expected", {31'b0, ram_q.size() != 0}, 32'd1);
                if (ram_q.size() != 0) begin
                    m = ram_q.pop_front();
                    check("ram_addr", 32'(ram_addr_o), 32'(m.addr));
                    check("ram_we", {31'b0, ram_we_o}, {31'b0, m.we});
                    check("ram_be", {28'b0, ram_be_o}, {28'b0, m.be});
                    check("ram_cycle", 32'(cyc), 32'(m.cyc));
                    if (m.we) check("ram_wdata", ram_wdata_o, m.wdata);
                end
            end else begin
                check("ram_idle_zero", {31'b0, |{ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o}},
                      32'd0);
            end
        end
    end

    task automatic if_txn(input logic [31:0] addr);
        int   n = 0;
        rsp_t r;
        ram_t m;
        @(negedge clk);
        if_addr_i      = addr;
        if_req_valid_i = 1'b1;
        #1;
        while (!if_req_ready_o && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!if_req_ready_o) begin
            check("if_ready_timeout", {31'b0, if_req_ready_o}, 32'd1);
            if_req_valid_i = 1'b0;
            return;
        end
        grant_log.push_back("I");
        m.addr  = addr[DEPTH_LOG2+1:2];
        m.we    = 1'b0;
        m.be    = 4'b0000;
        m.wdata = '0;
        m.cyc   = cyc + 1;
        ram_q.push_back(m);
        r.data = ref_mem[addr[DEPTH_LOG2+1:2]];
        r.err  = 1'b0;
        r.cyc  = cyc + 3;
        if_q.push_back(r);
        @(posedge clk);
        #1;
        if_req_valid_i = 1'b0;
    endtask

    task automatic lsu_txn(input logic [31:0] addr, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata);
        int                    n = 0;
        int                    lo;
        int                    nb;
        logic [DEPTH_LOG2-1:0] idx;
        logic [31:0]           v;
        rsp_t                  r;
        ram_t                  m;
        @(negedge clk);
        lsu_addr_i      = addr;
        lsu_we_i        = we;
        lsu_size_i      = size;
        lsu_unsigned_i  = uns;
        lsu_wdata_i     = wdata;
        lsu_req_valid_i = 1'b1;
        #1;
        while (!lsu_req_ready_o && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!lsu_req_ready_o) begin
            check("lsu_ready_timeout", {31'b0, lsu_req_ready_o}, 32'd1);
            lsu_req_valid_i = 1'b0;
            return;
        end
        grant_log.push_back("L");
        idx = addr[DEPTH_LOG2+1:2];
        lo  = int'(addr[1:0]);
        nb  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        r.data = 32'h0;
        r.err  = 1'b0;
        if (lo % nb != 0) begin
            r.err = 1'b1;
            r.cyc = cyc + 2;
        end else begin
            m.addr  = idx;
            m.we    = we;
            m.be    = 4'b0000;
            m.wdata = '0;
            m.cyc   = cyc + 1;
            if (we) begin
                for (int k = 0; k < nb; k++) begin
                    ref_mem[idx][8*(lo+k) +: 8] = wdata[8*k +: 8];
                    m.be[lo+k] = 1'b1;
                end
                for (int k = 0; k < 4; k++) m.wdata[8*k +: 8] = wdata[8*(k % nb) +: 8];
                r.cyc = cyc + 2;
            end else begin
                v = ref_mem[idx] >> (8 * lo);
                if (nb == 4)      r.data = v;
                else if (nb == 2) r.data = uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
                else              r.data = uns ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
                r.cyc = cyc + 3;
            end
            ram_q.push_back(m);
        end
        lsu_q.push_back(r);
        @(posedge clk);
        #1;
        lsu_req_valid_i = 1'b0;
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_if_rsp"}, {31'b0, if_rsp_valid_o}, 32'd0);
        check({name, "_if_data"}, if_rsp_data_o, 32'd0);
        check({name, "_lsu_rsp"}, {31'b0, lsu_rsp_valid_o}, 32'd0);
        check({name, "_lsu_data"}, lsu_rsp_data_o, 32'd0);
        check({name, "_lsu_err"}, {31'b0, lsu_err_o}, 32'd0);
        check({name, "_ram_en"}, {31'b0, ram_en_o}, 32'd0);
        check({name, "_ram_rest"}, {31'b0, |{ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o}},
              32'd0);
    endtask

    initial begin
        string exp_order;
        int    n;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        repeat (2) @(negedge clk);
        init_done = 1'b1;
        @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Directed cases.
        if_txn(32'h0000_0008);
        lsu_txn(32'h0000_0013, 1'b1, 2'b00, 1'b0, 32'h0000_00A5);
        lsu_txn(32'h0000_0013, 1'b0, 2'b00, 1'b0, 32'h0);
        lsu_txn(32'h0000_0013, 1'b0, 2'b00, 1'b1, 32'h0);
        lsu_txn(32'h0000_0001, 1'b0, 2'b01, 1'b0, 32'h0);
        lsu_txn(32'h0000_0006, 1'b1, 2'b10, 1'b0, 32'h1234_5678);
        lsu_txn(32'h0000_0204, 1'b0, 2'b10, 1'b0, 32'h0);
        if_txn(32'hFFFF_FE04);
        lsu_txn(32'h0000_0022, 1'b1, 2'b01, 1'b0, 32'hCAFE_8001);
        lsu_txn(32'h0000_0022, 1'b0, 2'b01, 1'b0, 32'h0);
        lsu_txn(32'h0000_0022, 1'b0, 2'b01, 1'b1, 32'h0);
        lsu_txn(32'h0000_0030, 1'b1, 2'b11, 1'b0, 32'h8765_4321);
        lsu_txn(32'h0000_0030, 1'b0, 2'b11, 1'b0, 32'h0);

        // Reset while a load is in ACCESS: no response, outputs cleared at once.
        lsu_txn(32'h0000_0040, 1'b0, 2'b10, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        lsu_q.delete();
        ram_q.delete();
        check_outputs_zero("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lsu_txn(32'h0000_0040, 1'b0, 2'b10, 1'b0, 32'h0);
        if_txn(32'h0000_0044);

        // Simultaneous requesters, four each.
        grant_log.delete();
        fork
            begin
                for (int i = 0; i < 4; i++)
                    lsu_txn({24'h0, 6'($urandom), 2'b00}, 1'($urandom), 2'b10, 1'b0, $urandom);
            end
            begin
                for (int i = 0; i < 4; i++) if_txn({24'h0, 6'($urandom), 2'b00});
            end
        join
`ifdef DRAM_ARB_RR_EN
        exp_order = "LILILILI";
`else
        exp_order = "LLLLIIII";
`endif
        check("arb_grant_count", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            check("arb_grant_order", {24'b0, grant_log[i]}, {24'b0, exp_order[i]});

        // Randomized mix.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1023)) : $urandom;
            if ($urandom_range(0, 3) == 0) if_txn(a);
            else lsu_txn(a, 1'($urandom), 2'($urandom), 1'($urandom), $urandom);
        end

        n = 0;
        while ((if_q.size() + lsu_q.size() + ram_q.size()) != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("drain_if", 32'(if_q.size()), 32'd0);
        check("drain_lsu", 32'(lsu_q.size()), 32'd0);
        check("drain_ram", 32'(ram_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
